pipe_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage core. Sequences the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Runs the two-cycle exception freeze-then-flush sequence and generates the redirect PC.
- Keeps stall statistics and a stall watchdog for debug.

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl_stall_wdog.sv | 53 +++++
 rtl/pipe_ctrl.sv | 89 ++++++++
 tb/tb_pipe_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall vectors, exception codes, FSM states.
// Imported by pipe_ctrl and its watchdog sub-module.
package pipe_ctrl_pkg;

  localparam logic RST_ACT = 1'b0;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INTR    = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  // req = {mem, ex, id, if}; the deepest requesting stage wins.
  function automatic logic [5:0] stall_encode(input logic [3:0] req);
    logic [5:0] s;
    if (req[3])      s = STALL_MEM;
    else if (req[2]) s = STALL_EX;
    else if (req[1]) s = STALL_ID;
    else if (req[0]) s = STALL_IF;
    else             s = STALL_NONE;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// The controller sits on the slave modport; the stage side uses master.
interface pipe_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cause;
  logic        stall_timeout;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_cycles, stall_cause, stall_timeout
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_cycles, stall_cause, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall statistics: consecutive-stall watchdog, saturating stall-cycle count, episode cause.
// All outputs registered; i_cnt_en marks a RUN cycle where the PC is held by a request.
module pipe_ctrl_stall_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(1024)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cnt_en,
  input  logic [3:0]  i_req,
  output logic [31:0] o_stall_cycles,
  output logic [3:0]  o_stall_cause,
  output logic        o_stall_timeout
);

  logic [WDOG_W-1:0] r_consec;
  logic [WDOG_W-1:0] w_consec_nxt;
  logic [31:0]       r_cycles;
  logic [3:0]        r_cause;
  logic              r_prev_en;
  logic              r_timeout;

  always_comb begin
    w_consec_nxt = '0;
    if (i_cnt_en) begin
      w_consec_nxt = (r_consec == '1) ? r_consec : r_consec + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT) begin
      r_consec  <= '0;
      r_cycles  <= '0;
      r_cause   <= '0;
      r_prev_en <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_consec  <= w_consec_nxt;
      r_prev_en <= i_cnt_en;
      if (i_cnt_en && (r_cycles != 32'hFFFF_FFFF)) r_cycles <= r_cycles + 32'd1;
      // Cause is sampled only on the rising edge of an episode.
      if (i_cnt_en && !r_prev_en) r_cause <= i_req;
      if (w_consec_nxt >= WDOG_LIMIT) r_timeout <= 1'b1;
    end
  end

  assign o_stall_cycles  = r_cycles;
  assign o_stall_cause   = r_cause;
  assign o_stall_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall mux plus RUN/FREEZE/FLUSH exception sequencer.
// Stall is combinational; flush/new_pc are registered one-cycle pulses.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0]       EXC_VECTOR = EXC_VECTOR_DFLT,
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(1024)
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_target;
  logic [31:0] r_new_pc;
  logic        r_flush;
  logic [3:0]  w_req;
  logic        w_exc;
  logic [5:0]  w_stall;
  logic        w_cnt_en;

  assign w_req = {bus.stallreq_from_mem, bus.stallreq_from_ex,
                  bus.stallreq_from_id,  bus.stallreq_from_if};
  assign w_exc = (bus.excepttype_i != EXC_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT) r_state <= ST_RUN;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_exc) w_state_nxt = ST_FREEZE;
      ST_FREEZE: w_state_nxt = ST_FLUSH;
      ST_FLUSH:  w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // Stall is forced low while reset is held so stages see a clean pipe.
  always_comb begin
    w_stall = STALL_NONE;
    if (rst != RST_ACT) begin
      case (r_state)
        ST_RUN:    w_stall = w_exc ? STALL_ALL : stall_encode(w_req);
        ST_FREEZE: w_stall = STALL_ALL;
        default:   w_stall = STALL_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT) begin
      r_target <= '0;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
    end else begin
      if ((r_state == ST_RUN) && w_exc) begin
        r_target <= (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
      end
      r_flush  <= (w_state_nxt == ST_FLUSH);
      r_new_pc <= (w_state_nxt == ST_FLUSH) ? r_target : '0;
    end
  end

  assign w_cnt_en = (r_state == ST_RUN) && !w_exc && w_stall[0];

  pipe_ctrl_stall_wdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_stall_wdog (
    .clk             (clk),
    .rst             (rst),
    .i_cnt_en        (w_cnt_en),
    .i_req           (w_req),
    .o_stall_cycles  (bus.stall_cycles),
    .o_stall_cause   (bus.stall_cause),
    .o_stall_timeout (bus.stall_timeout)
  );

  assign bus.stall  = w_stall;
  assign bus.flush  = r_flush;
  assign bus.new_pc = r_new_pc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic, all checked against
// a cycle-level behavioural model of the controller.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  pipe_ctrl_if bus();

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .WDOG_W     (16),
    .WDOG_LIMIT (16'd8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: phase counts cycles into an exception sequence (0 = normal running).
  int          phase;
  logic [31:0] m_target;
  longint      m_consec;
  longint      m_cycles;
  logic [3:0]  m_cause;
  logic        m_timeout;
  logic        m_prev;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] req_vec();
    return {bus.stallreq_from_mem, bus.stallreq_from_ex, bus.stallreq_from_id, bus.stallreq_from_if};
  endfunction

  function automatic logic [5:0] exp_stall();
    logic [3:0] r;
    r = req_vec();
    if (rst == 1'b0) return 6'd0;
    if (phase == 1) return 6'h3f;
    if (phase == 2) return 6'h00;
    if (bus.excepttype_i != 32'd0) return 6'h3f;
    // Stage k requesting holds k+2 low-order stall bits.
    for (int k = 3; k >= 0; k--) if (r[k]) return 6'((1 << (k + 2)) - 1);
    return 6'd0;
  endfunction

  task automatic model_reset();
    phase = 0; m_target = 0; m_consec = 0; m_cycles = 0;
    m_cause = 0; m_timeout = 0; m_prev = 0;
  endtask

  task automatic model_update();
    logic [3:0] r;
    logic       cnt;
    r   = req_vec();
    cnt = (phase == 0) && (bus.excepttype_i == 32'd0) && (r != 4'd0);
    if (cnt) begin
      if (!m_prev) m_cause = r;
      m_consec = (m_consec >= 65535) ? 65535 : m_consec + 1;
      m_cycles = (m_cycles >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cycles + 1;
      if (m_consec >= 8) m_timeout = 1'b1;
    end else begin
      m_consec = 0;
    end
    m_prev = cnt;
    case (phase)
      0: if (bus.excepttype_i != 32'd0) begin
           phase    = 1;
           m_target = (bus.excepttype_i == 32'h0000_000e) ? bus.cp0_epc_i : 32'h0000_0020;
         end
      1: phase = 2;
      default: phase = 0;
    endcase
  endtask

  task automatic check_all();
    check_val("stall", 64'(bus.stall), 64'(exp_stall()));
    check_val("flush", 64'(bus.flush), 64'(phase == 2));
    if (phase == 2) check_val("new_pc", 64'(bus.new_pc), 64'(m_target));
    check_val("stall_cycles", 64'(bus.stall_cycles), 64'(m_cycles));
    check_val("stall_cause", 64'(bus.stall_cause), 64'(m_cause));
    check_val("stall_timeout", 64'(bus.stall_timeout), 64'(m_timeout));
  endtask

  // Inputs change at negedge; check mid-cycle, then advance the model across the edge.
  task automatic step();
    #1;
    check_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic f, input logic d, input logic e, input logic m,
                        input logic [31:0] exc, input logic [31:0] epc);
    bus.stallreq_from_if  = f;
    bus.stallreq_from_id  = d;
    bus.stallreq_from_ex  = e;
    bus.stallreq_from_mem = m;
    bus.excepttype_i      = exc;
    bus.cp0_epc_i         = epc;
  endtask

  logic [31:0] codes [4];
  longint      saved_cycles;

  initial begin
    codes = '{32'h0000_0001, 32'h0000_000e, 32'h0000_0008, 32'h0000_000c};

    // Reset with a request pending: everything must read zero.
    rst = 1'b0;
    set_in(0, 0, 0, 1, 0, 0);
    model_reset();
    #1;
    check_all();
    check_val("rst_new_pc", 64'(bus.new_pc), 64'd0);
    repeat (2) @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Watchdog: eight consecutive fetch stalls trip the sticky flag.
    set_in(1, 0, 0, 0, 0, 0);
    repeat (7) step();
    check_val("wdog_pre", 64'(bus.stall_timeout), 64'd0);
    step();
    check_val("wdog_set", 64'(bus.stall_timeout), 64'd1);
    check_val("wdog_cycles", 64'(bus.stall_cycles), 64'd8);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    check_val("wdog_sticky", 64'(bus.stall_timeout), 64'd1);

    // Priority: mem beats id, then id alone once mem drops.
    set_in(0, 1, 0, 1, 0, 0);
    step();
    check_val("prio_cause", 64'(bus.stall_cause), 64'h0a);
    bus.stallreq_from_mem = 1'b0;
    #1;
    check_val("prio_id", 64'(bus.stall), 64'b000111);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    step();

    // Plain exception: two frozen cycles then a single flush to the vector.
    set_in(0, 0, 0, 0, 32'h0000_0001, 0);
    #1;
    check_val("exc_stall0", 64'(bus.stall), 64'h3f);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    check_val("exc_stall1", 64'(bus.stall), 64'h3f);
    step();
    check_val("exc_flush", 64'(bus.flush), 64'd1);
    check_val("exc_new_pc", 64'(bus.new_pc), 64'h20);
    check_val("exc_flush_stall", 64'(bus.stall), 64'd0);
    step();
    check_val("exc_flush_end", 64'(bus.flush), 64'd0);

    // ERET returns to the EPC captured at the faulting cycle, not a later one.
    set_in(0, 0, 0, 0, 32'h0000_000e, 32'h0000_1234);
    step();
    set_in(0, 0, 0, 0, 0, 32'h0000_dead);
    step();
    check_val("eret_new_pc", 64'(bus.new_pc), 64'h1234);
    step();

    // Exception with EX stall held: no stall cycles accrue through the sequence.
    saved_cycles = m_cycles;
    set_in(0, 0, 1, 0, 32'h0000_0008, 0);
    step();
    set_in(0, 0, 1, 0, 0, 0);
    step();
    #1;
    check_val("exh_flush_stall", 64'(bus.stall), 64'd0);
    step();
    check_val("exh_cycles", 64'(bus.stall_cycles), 64'(saved_cycles));
    set_in(0, 0, 0, 0, 0, 0);
    step();

    // Async reset in FREEZE aborts the sequence with no flush afterwards.
    set_in(0, 0, 0, 0, 32'h0000_0001, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    check_val("arst_stall", 64'(bus.stall), 64'd0);
    check_val("arst_new_pc", 64'(bus.new_pc), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();

    // Random traffic.
    repeat (1500) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             ($urandom_range(0, 9) == 0) ? codes[$urandom_range(0, 3)] : 32'd0,
             $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
